// File: rtl/counter_display_mux.sv
// N-digit up/down hex/BCD counter with parallel load, leading-zero blanking,
// rollover pulse and a registered time-multiplexed seven-segment scan output.
module counter_display_mux #(
    parameter int NUM_DISPLAYS         = 4,
    parameter int COUNTER_DIVISIONBITS = 2,
    parameter int SCAN_DIVISIONBITS    = 2
) (
    input  logic                          clk,
    input  logic                          count_reset,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          decimal,
    input  logic                          load,
    input  logic [NUM_DISPLAYS-1:0][3:0]  load_value,
    input  logic                          blank_zeros,
    output logic [NUM_DISPLAYS-1:0][6:0]  data,
    output logic [6:0]                    segments,
    output logic [NUM_DISPLAYS-1:0]       digit_sel,
    output logic                          wrap
);

    localparam int CPW = (COUNTER_DIVISIONBITS > 0) ? COUNTER_DIVISIONBITS : 1;
    localparam int SPW = (SCAN_DIVISIONBITS > 0) ? SCAN_DIVISIONBITS : 1;
    localparam int IW  = (NUM_DISPLAYS > 1) ? $clog2(NUM_DISPLAYS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DISPLAYS - 1);

    logic [CPW-1:0]                r_cnt_pre;
    logic [SPW-1:0]                r_scan_pre;
    logic [IW-1:0]                 r_scan_idx;
    logic [NUM_DISPLAYS-1:0][3:0]  r_digits;
    logic                          r_wrap;
    logic [6:0]                    r_segments;
    logic [NUM_DISPLAYS-1:0]       r_digit_sel;

    logic [NUM_DISPLAYS-1:0][3:0]  w_digits_next;
    logic [NUM_DISPLAYS-1:0][3:0]  w_load_digits;
    logic [3:0]                    w_max;
    logic                          w_carry;
    logic                          w_seen;
    logic                          w_cnt_full;
    logic                          w_scan_full;
    logic                          w_tick;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // A zero-width prescaler means "full" on every clock.
    generate
        if (COUNTER_DIVISIONBITS == 0) begin : g_cnt_nodiv
            assign w_cnt_full = 1'b1;
        end else begin : g_cnt_div
            assign w_cnt_full = &r_cnt_pre;
        end
        if (SCAN_DIVISIONBITS == 0) begin : g_scan_nodiv
            assign w_scan_full = 1'b1;
        end else begin : g_scan_div
            assign w_scan_full = &r_scan_pre;
        end
    endgenerate

    assign w_tick = enable & w_cnt_full;
    assign w_max  = decimal ? 4'd9 : 4'd15;

    // Ripple carry/borrow; w_carry left set after the top digit marks a full rollover.
    always_comb begin
        w_digits_next = r_digits;
        w_carry       = 1'b1;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (w_carry) begin
                if (up_down) begin
                    if (r_digits[i] >= w_max) begin
                        w_digits_next[i] = 4'd0;
                    end else begin
                        w_digits_next[i] = r_digits[i] + 4'd1;
                        w_carry          = 1'b0;
                    end
                end else begin
                    if (r_digits[i] == 4'd0) begin
                        w_digits_next[i] = w_max;
                    end else if (r_digits[i] > w_max) begin
                        w_digits_next[i] = w_max;
                        w_carry          = 1'b0;
                    end else begin
                        w_digits_next[i] = r_digits[i] - 4'd1;
                        w_carry          = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        w_load_digits = load_value;
        for (int i = 0; i < NUM_DISPLAYS; i++) begin
            if (decimal && (load_value[i] > 4'd9)) begin
                w_load_digits[i] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (count_reset) begin
            r_digits  <= '0;
            r_cnt_pre <= '0;
            r_wrap    <= 1'b0;
        end else if (load) begin
            r_digits  <= w_load_digits;
            r_cnt_pre <= '0;
            r_wrap    <= 1'b0;
        end else begin
            if (enable) begin
                r_cnt_pre <= w_cnt_full ? '0 : r_cnt_pre + 1'b1;
            end
            if (w_tick) begin
                r_digits <= w_digits_next;
                r_wrap   <= w_carry;
            end else begin
                r_wrap   <= 1'b0;
            end
        end
    end

    // Scan from the top digit down so every digit above the first non-zero one blanks.
    always_comb begin
        data   = '1;
        w_seen = 1'b0;
        for (int i = NUM_DISPLAYS - 1; i >= 0; i--) begin
            w_seen = w_seen | (r_digits[i] != 4'd0);
            if (blank_zeros && !w_seen && (i != 0)) begin
                data[i] = 7'b1111111;
            end else begin
                data[i] = seg7(r_digits[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (count_reset) begin
            r_scan_pre  <= '0;
            r_scan_idx  <= '0;
            r_segments  <= 7'b1000000;
            r_digit_sel <= ~NUM_DISPLAYS'(1);
        end else begin
            r_scan_pre  <= w_scan_full ? '0 : r_scan_pre + 1'b1;
            if (w_scan_full) begin
                r_scan_idx <= (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
            end
            r_segments  <= data[r_scan_idx];
            r_digit_sel <= ~(NUM_DISPLAYS'(1) << r_scan_idx);
        end
    end

    assign segments  = r_segments;
    assign digit_sel = r_digit_sel;
    assign wrap      = r_wrap;

endmodule

// File: doc/counter_display_mux.md
Name: counter_display_mux

Overview:
Parametrised N-digit counter with seven-segment output; successor to the fixed hex display counter. Adds up/down counting, selectable hex/BCD radix, parallel load, leading-zero blanking, a rollover pulse and a time-multiplexed scan output for boards with shared segment lines. Outputs go in two forms: per-digit parallel segment data, and the scanned segments plus digit select. All display outputs are active low.

Parameters:
NUM_DISPLAYS, 4, number of digits (>=1)
COUNTER_DIVISIONBITS, 2, count prescaler width; one count step per 2^COUNTER_DIVISIONBITS enabled clocks (0 = every enabled clock)
SCAN_DIVISIONBITS, 2, scan prescaler width; scan advances one digit per 2^SCAN_DIVISIONBITS clocks (0 = every clock)

Ports:
clk  input  1  system clock, all state on rising edge
count_reset  input  1  synchronous, active-high reset
enable  input  1  count prescaler runs while high
up_down  input  1  1 = count up, 0 = count down
decimal  input  1  1 = BCD digits (0-9), 0 = hex digits (0-F)
load  input  1  load load_value on next edge
load_value  input  [NUM_DISPLAYS-1:0][3:0]  parallel load digits, [0] = least significant
blank_zeros  input  1  enable leading-zero blanking
data  output  [NUM_DISPLAYS-1:0][6:0]  per-digit segments, active low, bit0=a..bit6=g
segments  output  7  scanned segments, active low, registered
digit_sel  output  NUM_DISPLAYS  scanned digit select, active low, one-cold, registered
wrap  output  1  one-cycle pulse on full-count rollover

Behaviour:
- Priority per edge: count_reset > load > tick > hold.
- Reset: all digits 0, both prescalers 0, scan index 0, wrap 0, digit_sel bit0 low and all other bits high, segments 7'b1000000.
- Count prescaler increments only when enable=1. tick = enable & (prescaler all ones). Prescaler wraps to 0 after the tick.
- load: digits <= load_value, with each digit clamped to 9 when decimal=1. Count prescaler cleared. wrap=0. Any coincident tick is discarded.
- Tick, up: digit0 +1. A digit at max, or above max after a mode change, becomes 0 and carries; the carry ripples within the same cycle. max = 9 (decimal) or 15 (hex).
- Tick, down: digit0 -1. A digit at 0 becomes max and borrows. A digit above max becomes max with no borrow.
- wrap is registered and high for exactly the cycle after the edge where all digits go max->0 (up) or 0->max (down). Otherwise wrap is 0.
- data is combinational from the digit registers, so it is valid in the same cycle as the count.
- Decode uses standard hex patterns: 0=1000000, 1=1111001, 2=0100100, 4=0011001, 5=0010010, 8=0000000, 9=0010000, A=0001000, F=0001110. Blank = 1111111.
- Blanking applies when blank_zeros=1: every digit above the most significant non-zero digit is blank. Digit 0 is never blanked.
- Scan: the scan prescaler is free running and not gated by enable. When it is all ones, the scan index advances, wrapping NUM_DISPLAYS-1 -> 0. digit_sel and segments are registered from the index and data[index]. They are one cycle behind data.
- Reset mid-operation: every register returns to its reset value on the next edge, whatever load/enable are doing.

Test Plan:
(NUM_DISPLAYS=2, COUNTER_DIVISIONBITS=2, SCAN_DIVISIONBITS=1)
- Hex up: reset, enable=1, up_down=1, decimal=0 for 16 clocks -> count 0x04, data[0]=0011001, data[1]=1000000, wrap never high.
- Decimal up: load_value={9,8}, decimal=1, load 1 cycle, then 8 enabled clocks -> 99, then 00. wrap high for exactly one cycle. The same run with decimal=0 gives 0x9A.
- Hex down: from 00, up_down=0, 4 enabled clocks -> FF, data={0001110,0001110}, one wrap pulse.
- Load/tick collision: assert load on the tick cycle -> load_value taken, no step. The next step comes exactly 4 enabled clocks after the load.
- Blanking: count 05, blank_zeros=1 -> data[1]=1111111, data[0]=0010010. Count 00 -> data[0]=1000000.
- Scan/reset: digit_sel alternates 10/01 every 2 clocks with segments matching data of the selected digit, one cycle late. Assert count_reset mid-count -> next cycle count 00, digit_sel=10, segments=1000000, wrap=0.
